// File: rtl/sram_access_ctrl.sv
// Multi-cycle bridge from the MEM stage's 32-bit load/store to a 16-bit async SRAM.
// Each word is moved as two half-word accesses while freeze holds the pipeline.
module sram_access_ctrl #(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        freeze,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_op_q, wr_op_d;
  logic [16:0] w_q, w_d;
  logic [15:0] whi_q, whi_d;
  logic [31:0] rdata_q, rdata_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] dq_q, dq_d;

  logic [16:0] w_in;
  logic        req;
  logic        last;
  logic        busy;

  // Word index wraps modulo 2^17 words; no range check is intended.
  assign w_in = 17'((addr - BASE_ADDR) >> 2);
  assign req  = wr_en | rd_en;
  assign last = (cnt_q == LAST);
  assign busy = (state_q == LO) || (state_q == HI);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_op_d = wr_op_q;
    w_d     = w_q;
    whi_d   = whi_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    dq_d    = dq_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LO;
          cnt_d   = 4'd0;
          wr_op_d = wr_en;
          w_d     = w_in;
          whi_d   = wdata[31:16];
          addr_d  = {w_in, 1'b0};
          dq_d    = wdata[15:0];
        end
      end
      LO: begin
        if (last) begin
          state_d = HI;
          cnt_d   = 4'd0;
          addr_d  = {w_q, 1'b1};
          dq_d    = whi_q;
          if (!wr_op_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = 4'd0;
          if (!wr_op_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_op_q <= 1'b0;
      w_q     <= 17'd0;
      whi_q   <= 16'd0;
      rdata_q <= 32'd0;
      addr_q  <= 18'd0;
      dq_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_op_q <= wr_op_d;
      w_q     <= w_d;
      whi_q   <= whi_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
    end
  end

  // Strobes decode from registered state so an async reset idles the pins at once;
  // we_n lifts on the last cycle of each half so data/address hold past the write edge.
  assign sram_dq_oe  = busy & wr_op_q;
  assign sram_we_n   = ~(busy & wr_op_q & ~last);
  assign sram_oe_n   = ~(busy & ~wr_op_q);
  assign ready       = (state_q == DONE);
  assign freeze      = reset_n & (((state_q == IDLE) & req) | busy);
  assign rdata       = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: half-word SRAM model on the pins and a word-level
// reference memory used to predict every read.
module tb_sram_access_ctrl;

  localparam int          W    = 3;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en, rd_en;
  logic [31:0] addr, wdata, rdata;
  logic        ready, freeze;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  int vectors = 0;
  int errs    = 0;

  logic [15:0] mem [0:262143];
  logic [31:0] refm [int];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  sram_access_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .freeze(freeze),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  // SRAM drives the bus only with oe_n low; otherwise the bus floats high.
  assign sram_dq_in = sram_oe_n ? 16'hFFFF : mem[sram_addr];

  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input int wi);
    return refm.exists(wi) ? refm[wi] : 32'd0;
  endfunction

  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input bit drop);
    logic [16:0] wi;
    bit          is_wr;
    logic [31:0] exp_rd;
    int          pos;
    bit          half;
    wi    = 17'((a - BASE) >> 2);
    is_wr = wr;
    if (is_wr) begin
      refm[int'(wi)] = d;
      exp_rd = last_rd;
    end else begin
      exp_rd  = ref_read(int'(wi));
      last_rd = exp_rd;
    end
    @(negedge clk);
    reset_n = 1'b1;
    wr_en = wr; rd_en = rd; addr = a; wdata = d;
    #1;
    check("freeze_req_cycle", 32'(freeze), 32'd1);
    check("ready_req_cycle", 32'(ready), 32'd0);
    for (int k = 1; k <= 2*W + 1; k++) begin
      @(negedge clk);
      if (k <= 2*W) begin
        half = (k > W);
        pos  = (k - 1) % W;
        check("freeze_busy", 32'(freeze), 32'd1);
        check("ready_busy", 32'(ready), 32'd0);
        check("sram_addr", 32'(sram_addr), 32'({wi, half}));
        check("we_n", 32'(sram_we_n), (is_wr && pos != W-1) ? 32'd0 : 32'd1);
        check("oe_n", 32'(sram_oe_n), is_wr ? 32'd1 : 32'd0);
        check("dq_oe", 32'(sram_dq_oe), is_wr ? 32'd1 : 32'd0);
        if (is_wr) check("dq_out", 32'(sram_dq_out), half ? 32'(d[31:16]) : 32'(d[15:0]));
      end else begin
        check("ready_done", 32'(ready), 32'd1);
        check("freeze_done", 32'(freeze), 32'd0);
        check("we_n_done", 32'(sram_we_n), 32'd1);
        check("oe_n_done", 32'(sram_oe_n), 32'd1);
        check("rdata_done", rdata, exp_rd);
      end
      if (drop && k == 1) begin
        wr_en = 1'b0; rd_en = 1'b0;
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("freeze_idle", 32'(freeze), 32'd0);
    check("ready_idle", 32'(ready), 32'd0);
    check("pins_idle", {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b110);
    check("rdata_hold", rdata, exp_rd);
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'd0;
    last_rd = 32'd0;
    reset_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b1; addr = BASE; wdata = 32'd0;

    // Reset held with a request pending
    repeat (3) @(negedge clk);
    #1;
    check("rst_freeze", 32'(freeze), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_out", 32'(sram_dq_out), 32'd0);
    check("rst_pins", {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b110);

    // Release with rd_en still high: freeze rises in the same cycle
    access(1'b0, 1'b1, BASE, 32'd0, 1'b0);

    // Write-then-read
    access(1'b1, 1'b0, BASE, 32'hDEADBEEF, 1'b0);
    check("mem_lo", 32'(mem[0]), 32'h0000BEEF);
    check("mem_hi", 32'(mem[1]), 32'h0000DEAD);
    access(1'b0, 1'b1, BASE, 32'd0, 1'b0);

    // Strobe shape at 1028 (half addresses 2 and 3)
    access(1'b1, 1'b0, BASE + 32'd4, 32'hCAFE0123, 1'b0);
    check("mem_2", 32'(mem[2]), 32'h00000123);
    check("mem_3", 32'(mem[3]), 32'h0000CAFE);

    // Both requests: write wins
    access(1'b1, 1'b1, BASE + 32'd8, 32'hA5A55A5A, 1'b0);
    access(1'b0, 1'b1, BASE + 32'd8, 32'd0, 1'b0);

    // Request dropped during LO
    access(1'b0, 1'b1, BASE + 32'd4, 32'd0, 1'b1);

    // Address below the base wraps
    access(1'b1, 1'b0, 32'd0, 32'h13572468, 1'b0);
    access(1'b0, 1'b1, 32'd0, 32'd0, 1'b0);

    // Reset during HI of a write
    @(negedge clk);
    wr_en = 1'b1; addr = BASE + 32'd20000; wdata = 32'h0BADF00D;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("abort_freeze", 32'(freeze), 32'd0);
    wr_en = 1'b0;
    last_rd = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("abort_no_ready", 32'(ready), 32'd0);
    end
    check("abort_rdata", rdata, 32'd0);

    // Randomized traffic over a small window
    for (int n = 0; n < 24; n++) begin
      bit          r_wr, r_rd, r_drop;
      logic [31:0] r_a, r_d;
      r_wr   = $urandom_range(0, 1) == 1;
      r_rd   = r_wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      r_drop = $urandom_range(0, 2) == 0;
      r_a    = BASE + 32'(4 * $urandom_range(0, 15));
      r_d    = $urandom;
      access(r_wr, r_rd, r_a, r_d, r_drop);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
# sram_access_ctrl

Multi-cycle controller that serves the MEM stage's 32-bit load/store requests from an off-chip 16-bit asynchronous SRAM. It splits each word access into two half-word accesses and drives `freeze` so the pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) hold their contents until the access completes. It sits between the MEM stage and the SRAM pins, and is the only source of the pipeline's SRAM freeze signal.

## Interface
- `WAIT_CYCLES`, 3: cycles per half-word access; legal range 2..15.
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  store request from MEM stage (level, held while frozen).
- `rd_en`  in  1  load request from MEM stage (level, held while frozen).
- `addr`  in  32  byte address from the ALU result.
- `wdata`  in  32  store data (Val_Rm).
- `rdata`  out  32  load data; valid in the `ready` cycle, then held.
- `ready`  out  1  one-cycle pulse marking access completion.
- `freeze`  out  1  pipeline hold; routed to every pipeline register's freeze input.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_dq_out`  out  16  data driven to SRAM.
- `sram_dq_oe`  out  1  tristate enable for `sram_dq_out`.
- `sram_dq_in`  in  16  data read from SRAM.
- `sram_we_n`  out  1  SRAM write strobe, active-low.
- `sram_oe_n`  out  1  SRAM output enable, active-low.

## Operation
- Word index: `w = (addr - BASE_ADDR) >> 2`, truncated to 17 bits. The low half is at `sram_addr = {w, 1'b0}` and the high half at `{w, 1'b1}`. Out-of-range addresses wrap modulo 2^17 words and raise no error.
- FSM states: `IDLE`, `LO`, `HI`, `DONE`. A 4-bit counter `cnt` counts 0..WAIT_CYCLES-1 inside `LO` and `HI`.
- `IDLE`: if `wr_en|rd_en`, latch op, `w` and `wdata`, then go to `LO` with `cnt=0`. `wr_en` has priority when both are high.
- `LO`: drives the low-half address. Advances to `HI` with `cnt=0` when `cnt==WAIT_CYCLES-1`.
- `HI`: drives the high-half address. Advances to `DONE` when `cnt==WAIT_CYCLES-1`.
- `DONE`: `ready=1`, `freeze=0`. Always returns to `IDLE` on the next cycle.
- Writes:
  - `sram_dq_oe=1` throughout `LO`/`HI`.
  - `sram_dq_out` is `wdata[15:0]` in `LO` and `wdata[31:16]` in `HI`.
  - `sram_we_n=0` when `cnt != WAIT_CYCLES-1`. The strobe rises one cycle before the address changes.
  - `sram_oe_n=1` for the whole write.
- Reads:
  - `sram_oe_n=0` in `LO`/`HI`; `sram_we_n=1`; `sram_dq_oe=0`.
  - `sram_dq_in` is captured into `rdata[15:0]` on the last `LO` cycle and into `rdata[31:16]` on the last `HI` cycle.
  - `rdata` is held until the next read completes. Writes never alter it.
- `freeze = (IDLE & (wr_en|rd_en)) | LO | HI`. The term is combinational and forced to 0 while `reset_n` is low.
- Deasserting a request mid-access does not abort it. The access completes and `ready` still pulses.
- In `IDLE` with no request, the SRAM is idle: `we_n=1`, `oe_n=1`, `dq_oe=0`.

## Timing
- Reset (async, `reset_n=0`):
  - state `IDLE`, `cnt=0`.
  - `rdata=0`, `ready=0`, `freeze=0`.
  - `sram_addr=0`, `sram_dq_out=0`, `sram_dq_oe=0`.
  - `sram_we_n=1`, `sram_oe_n=1`.
- Reset asserted mid-access aborts immediately: pins return to idle and no `ready` is produced.
- Request first seen in cycle T:
  - `freeze=1` in cycles T..T+2·WAIT_CYCLES.
  - `ready=1` with `freeze=0` in cycle T+2·WAIT_CYCLES+1.
  - With the default WAIT_CYCLES=3, `freeze` is high for 7 cycles and `ready` comes on the 8th.
- The pipeline advances on the edge ending the `DONE` cycle. A new request is accepted no earlier than the following `IDLE` cycle, so back-to-back accesses are separated by exactly one `IDLE` cycle.
- `sram_addr` and `sram_dq_out` are registered outputs. They change only on state or half transitions.

## Test plan
- Reset: hold `reset_n=0` with `rd_en=1` -> every output at its reset value and `freeze=0`. Release -> `freeze=1` in the same cycle.
- Write-then-read: write `addr=1024`, `wdata=32'hDEADBEEF` to an SRAM model -> model holds `16'hBEEF` at 0 and `16'hDEAD` at 1, and `freeze` is high for 7 cycles. Then read `addr=1024` -> `rdata=32'hDEADBEEF` in the `ready` cycle.
- Strobe shape: write to `addr=1028` -> `sram_addr` is 2 then 3. `sram_we_n` is low for 2 cycles in each half and high in the last cycle of each half.
- Priority: `wr_en=1` and `rd_en=1` together -> a write is performed and `sram_oe_n` stays 1.
- Request dropped mid-access: deassert `rd_en` in `LO` -> the access still completes and `ready` pulses at T+7.
- Reset mid-access: pulse `reset_n` low during `HI` of a write -> `sram_we_n=1` and `sram_dq_oe=0` immediately, and no `ready` pulse follows.
